// File: rtl/debug_scan_reader.sv
// Host-side scanner for the SNN debug port: steps through every debug
// selection code, pulses the config write, waits for the value to settle,
// samples it and streams it out as one byte per code on a valid/ready link.
module debug_scan_reader #(
   parameter int NUM_POT = 24,
   parameter int SETTLE  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   output logic [7:0] cfg_out,
   output logic       cfg_en,
   input  logic [7:0] dbg_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   input  logic       byte_ready,
   output logic       frame_first,
   output logic       busy,
   output logic       done
);

   localparam int NBYTES = NUM_POT + 3;
   localparam int KW     = $clog2(NBYTES);

   localparam logic [KW-1:0] K_ZERO = KW'(0);
   localparam logic [KW-1:0] K_ONE  = KW'(1);
   localparam logic [KW-1:0] K_L1   = KW'(NUM_POT);
   localparam logic [KW-1:0] K_L2   = KW'(NUM_POT + 1);
   localparam logic [KW-1:0] K_LAST = KW'(NBYTES - 1);
   localparam logic [3:0]    SETTLE_C = 4'(SETTLE);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_WAIT,
      S_SEND,
      S_FIN
   } state_t;

   state_t        state_q;
   logic [KW-1:0] k_q;
   logic [3:0]    cnt_q;
   logic [7:0]    cfg_out_q;
   logic          cfg_en_q;
   logic [7:0]    byte_data_q;
   logic          byte_valid_q;
   logic          busy_q;
   logic          done_q;

   logic [KW-1:0] k_d;
   logic [7:0]    code_next_d;
   logic [7:0]    code_first_d;

   // Selection code for frame index k: potentials first, then the three
   // layer spike vectors at their fixed debug addresses.
   function automatic logic [7:0] code_of(input logic [KW-1:0] k);
      logic [7:0] c;
      if (k < K_L1) begin
         c = 8'(k);
      end else if (k == K_L1) begin
         c = 8'h1E;
      end else if (k == K_L2) begin
         c = 8'h1F;
      end else begin
         c = 8'h20;
      end
      return c;
   endfunction

   // Next frame index and the codes driven on entry to LOAD.
   always_comb begin
      k_d          = k_q + K_ONE;
      code_next_d  = code_of(k_d);
      code_first_d = code_of(K_ZERO);
   end

   // Scan FSM; every output is registered so cfg_en is high exactly in LOAD.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         k_q          <= K_ZERO;
         cnt_q        <= 4'd0;
         cfg_out_q    <= 8'h00;
         cfg_en_q     <= 1'b0;
         byte_data_q  <= 8'h00;
         byte_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         cfg_en_q <= 1'b0;
         done_q   <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  k_q       <= K_ZERO;
                  cfg_out_q <= code_first_d;
                  cfg_en_q  <= 1'b1;
                  busy_q    <= 1'b1;
                  state_q   <= S_LOAD;
               end
            end
            S_LOAD: begin
               cnt_q   <= SETTLE_C;
               state_q <= S_WAIT;
            end
            S_WAIT: begin
               // Sample on the last settle cycle; <= guards a zero count.
               if (cnt_q <= 4'd1) begin
                  byte_data_q  <= dbg_in;
                  byte_valid_q <= 1'b1;
                  state_q      <= S_SEND;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            S_SEND: begin
               // byte_data_q is untouched here, so it is stable while valid.
               if (byte_ready) begin
                  byte_valid_q <= 1'b0;
                  if (k_q != K_LAST) begin
                     k_q       <= k_d;
                     cfg_out_q <= code_next_d;
                     cfg_en_q  <= 1'b1;
                     state_q   <= S_LOAD;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= S_FIN;
                  end
               end
            end
            S_FIN: begin
               if (continuous) begin
                  k_q       <= K_ZERO;
                  cfg_out_q <= code_first_d;
                  cfg_en_q  <= 1'b1;
                  state_q   <= S_LOAD;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cfg_out     = cfg_out_q;
   assign cfg_en      = cfg_en_q;
   assign byte_data   = byte_data_q;
   assign byte_valid  = byte_valid_q;
   assign frame_first = byte_valid_q && (k_q == K_ZERO);
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_debug_scan_reader.sv
// Bench for debug_scan_reader: two instances (SETTLE=1 and SETTLE=3), each
// driving its own model debug port; a monitor logs config writes, accepted
// bytes and done pulses, which are compared against a frame table.
module tb_debug_scan_reader;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Instance A: defaults
   logic       a_start, a_cont, a_cfg_en, a_valid, a_ready, a_first, a_busy, a_done;
   logic [7:0] a_cfg_out, a_dbg, a_data;
   // Instance B: SETTLE=3
   logic       b_start, b_cont, b_cfg_en, b_valid, b_ready, b_first, b_busy, b_done;
   logic [7:0] b_cfg_out, b_dbg, b_data;

   debug_scan_reader dut_a (
      .clk(clk), .rst_n(rst_n), .start(a_start), .continuous(a_cont),
      .cfg_out(a_cfg_out), .cfg_en(a_cfg_en), .dbg_in(a_dbg),
      .byte_data(a_data), .byte_valid(a_valid), .byte_ready(a_ready),
      .frame_first(a_first), .busy(a_busy), .done(a_done)
   );

   debug_scan_reader #(.NUM_POT(24), .SETTLE(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(b_start), .continuous(b_cont),
      .cfg_out(b_cfg_out), .cfg_en(b_cfg_en), .dbg_in(b_dbg),
      .byte_data(b_data), .byte_valid(b_valid), .byte_ready(b_ready),
      .frame_first(b_first), .busy(b_busy), .done(b_done)
   );

   // Model debug ports: config register written on cfg_en, value decoded
   // combinationally from it. dbg_force overrides A's output.
   logic [7:0] a_cfg_reg = 8'h00;
   logic [7:0] b_cfg_reg = 8'h00;
   logic       dbg_force = 1'b0;
   always @(posedge clk) if (a_cfg_en) a_cfg_reg <= a_cfg_out;
   always @(posedge clk) if (b_cfg_en) b_cfg_reg <= b_cfg_out;

   function automatic logic [7:0] port_value(input logic [7:0] code);
      if (code < 8'd24) return code + 8'h40;
      if (code == 8'h1E) return 8'hA1;
      if (code == 8'h1F) return 8'hB2;
      if (code == 8'h20) return 8'hC3;
      return 8'h00;
   endfunction

   assign a_dbg = dbg_force ? 8'hEE : port_value(a_cfg_reg);
   assign b_dbg = port_value(b_cfg_reg);

   // Monitor source select: 0 = instance A, 1 = instance B
   logic       sel = 1'b0;
   logic       m_cfg_en, m_valid, m_ready, m_first, m_done;
   logic [7:0] m_cfg_out, m_data;
   assign m_cfg_en  = sel ? b_cfg_en  : a_cfg_en;
   assign m_cfg_out = sel ? b_cfg_out : a_cfg_out;
   assign m_valid   = sel ? b_valid   : a_valid;
   assign m_ready   = sel ? b_ready   : a_ready;
   assign m_first   = sel ? b_first   : a_first;
   assign m_data    = sel ? b_data    : a_data;
   assign m_done    = sel ? b_done    : a_done;

   logic [7:0] cfg_codes[$];
   int         cfg_cycs[$];
   logic [7:0] acc_data[$];
   logic       acc_first[$];
   int         vrise_cycs[$];
   int         done_cycs[$];
   int         stray_first = 0;
   logic       prev_valid = 1'b0;

   // Log every transaction at the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (m_cfg_en) begin
         cfg_codes.push_back(m_cfg_out);
         cfg_cycs.push_back(cyc);
      end
      if (m_valid && !prev_valid) vrise_cycs.push_back(cyc);
      if (m_first && !m_valid) stray_first = stray_first + 1;
      if (m_valid && m_ready) begin
         $display("[cyc %0d] byte %0d data=0x%02h first=%0b", cyc, acc_data.size(), m_data, m_first);
         acc_data.push_back(m_data);
         acc_first.push_back(m_first);
      end
      if (m_done) begin
         $display("[cyc %0d] done", cyc);
         done_cycs.push_back(cyc);
      end
      prev_valid = m_valid;
   end

   // Expected frame: selection code, model port value, first-byte flag.
   typedef struct {
      logic [7:0] code;
      logic [7:0] data;
      logic       first;
   } vec_t;
   vec_t vecs[27];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (act !== exp) begin
         n_bad = n_bad + 1;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      cfg_codes.delete();
      cfg_cycs.delete();
      acc_data.delete();
      acc_first.delete();
      vrise_cycs.delete();
      done_cycs.delete();
      stray_first = 0;
   endtask

   task automatic wait_done_n(input int n, input int budget);
      for (int i = 0; i < budget && done_cycs.size() < n; i++) tick(1);
      check("done_within_budget", done_cycs.size() >= n, 1);
   endtask

   task automatic check_frame(input int base);
      check("frame_bytes_present", acc_data.size() >= base + 27, 1);
      for (int i = 0; i < 27; i++) begin
         if (base + i < acc_data.size()) begin
            check($sformatf("byte_data[%0d]", base + i), acc_data[base + i], vecs[i].data);
            check($sformatf("frame_first[%0d]", base + i), acc_first[base + i], vecs[i].first);
         end
      end
   endtask

   int t0;

   initial begin
      a_start = 0; a_cont = 0; a_ready = 1;
      b_start = 0; b_cont = 0; b_ready = 1;
      rst_n = 0;
      for (int i = 0; i < 24; i++) vecs[i] = '{code: 8'(i), data: 8'(8'h40 + i), first: (i == 0)};
      vecs[24] = '{code: 8'h1E, data: 8'hA1, first: 1'b0};
      vecs[25] = '{code: 8'h1F, data: 8'hB2, first: 1'b0};
      vecs[26] = '{code: 8'h20, data: 8'hC3, first: 1'b0};

      // Reset state
      tick(3);
      check("rst_cfg_out", a_cfg_out, 0);
      check("rst_cfg_en", a_cfg_en, 0);
      check("rst_byte_data", a_data, 0);
      check("rst_byte_valid", a_valid, 0);
      check("rst_frame_first", a_first, 0);
      check("rst_busy", a_busy, 0);
      check("rst_done", a_done, 0);
      rst_n = 1;
      tick(2);

      // Asynchronous reset in the middle of WAIT
      clear_logs();
      a_start = 1; tick(1); a_start = 0;   // LOAD
      tick(1);                              // WAIT
      check("midwait_busy_before", a_busy, 1);
      #2 rst_n = 0;
      #1;
      check("midwait_rst_busy", a_busy, 0);
      check("midwait_rst_cfg_en", a_cfg_en, 0);
      check("midwait_rst_valid", a_valid, 0);
      check("midwait_rst_data", a_data, 0);
      check("midwait_rst_cfg_out", a_cfg_out, 0);
      check("midwait_rst_done", a_done, 0);
      tick(2);
      rst_n = 1;
      tick(5);
      check("after_rst_busy", a_busy, 0);
      check("after_rst_no_done", done_cycs.size(), 0);
      check("after_rst_no_bytes", acc_data.size(), 0);

      // Single frame at defaults
      clear_logs();
      t0 = cyc;
      a_start = 1; tick(1); a_start = 0;
      wait_done_n(1, 200);
      tick(3);
      check("frame_len", acc_data.size(), 27);
      check_frame(0);
      if (done_cycs.size() > 0) check("done_latency", done_cycs[0] - t0, 82);
      check("done_count", done_cycs.size(), 1);
      check("cfg_count", cfg_codes.size(), 27);
      for (int i = 0; i < 27; i++) begin
         if (i < cfg_codes.size()) begin
            check($sformatf("cfg_code[%0d]", i), cfg_codes[i], vecs[i].code);
            if (i == 0) check("cfg_first_cycle", cfg_cycs[0] - t0, 1);
            else check($sformatf("cfg_spacing[%0d]", i), cfg_cycs[i] - cfg_cycs[i-1], 3);
         end
      end
      if (vrise_cycs.size() > 0 && cfg_cycs.size() > 0)
         check("valid_after_cfg", vrise_cycs[0] - cfg_cycs[0], 2);
      check("cfg_out_hold", a_cfg_out, 8'h20);
      check("idle_busy", a_busy, 0);
      check("stray_first", stray_first, 0);

      // Backpressure on byte 3 with the debug port changing underneath
      clear_logs();
      t0 = cyc;
      a_start = 1; tick(1); a_start = 0;
      for (int i = 0; i < 50 && !(acc_data.size() == 3 && a_valid); i++) tick(1);
      check("stall_reached_byte3", (acc_data.size() == 3) && a_valid, 1);
      a_ready = 0;
      dbg_force = 1;
      for (int i = 0; i < 5; i++) begin
         check($sformatf("stall_valid[%0d]", i), a_valid, 1);
         check($sformatf("stall_data[%0d]", i), a_data, 8'h43);
         tick(1);
      end
      check("stall_bytes_held", acc_data.size(), 3);
      a_ready = 1;
      dbg_force = 0;
      wait_done_n(1, 200);
      tick(3);
      check("bp_frame_len", acc_data.size(), 27);
      check_frame(0);
      if (done_cycs.size() > 0) check("bp_done_latency", done_cycs[0] - t0, 87);

      // SETTLE=3 instance
      sel = 1;
      tick(1);
      clear_logs();
      t0 = cyc;
      b_start = 1; tick(1); b_start = 0;
      wait_done_n(1, 400);
      tick(3);
      check("s3_frame_len", acc_data.size(), 27);
      check_frame(0);
      if (done_cycs.size() > 0) check("s3_done_latency", done_cycs[0] - t0, 136);
      check("s3_cfg_count", cfg_codes.size(), 27);
      for (int i = 0; i < 27; i++) begin
         if (i < vrise_cycs.size() && i < cfg_cycs.size())
            check($sformatf("s3_valid_delay[%0d]", i), vrise_cycs[i] - cfg_cycs[i], 4);
      end
      check("s3_idle_busy", b_busy, 0);
      sel = 0;
      tick(1);

      // Continuous mode: two frames, a start while busy, then back to IDLE
      clear_logs();
      a_cont = 1;
      t0 = cyc;
      a_start = 1; tick(1); a_start = 0;
      tick(10);
      a_start = 1; tick(1); a_start = 0;
      wait_done_n(1, 200);
      tick(2);
      check("cont_busy_between", a_busy, 1);
      a_cont = 0;
      wait_done_n(2, 200);
      tick(10);
      check("cont_bytes", acc_data.size(), 54);
      check("cont_done_count", done_cycs.size(), 2);
      check_frame(0);
      check_frame(27);
      if (done_cycs.size() >= 2) begin
         check("cont_done1_latency", done_cycs[0] - t0, 82);
         check("cont_done_spacing", done_cycs[1] - done_cycs[0], 82);
      end
      if (cfg_cycs.size() > 27 && done_cycs.size() > 0)
         check("cont_load_after_fin", cfg_cycs[27] - done_cycs[0], 1);
      check("cont_idle_busy", a_busy, 0);
      check("cont_stray_first", stray_first, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/debug_scan_reader.md
# debug_scan_reader

Host-side reader for the SNN debug port. It walks every debug selection code in order and, for each code, pulses the port's config-write enable. It then waits for the selected value to settle and samples the 8-bit debug output. Each sample goes out as a byte on a valid/ready stream toward the chip-level output/UART path. One pass produces one frame: 24 membrane potentials followed by the spike vectors of layers 1, 2 and 3.

## Interface
Parameters:
- NUM_POT, 24, number of membrane-potential codes scanned (codes 0..NUM_POT-1).
- SETTLE, 1, wait cycles after a config write before sampling; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin one frame; sampled only in IDLE
- continuous  in  1  when 1, the next frame starts automatically after the current one; sampled at end of frame
- cfg_out  out  8  selection code driven to the debug port's config input
- cfg_en  out  1  one-cycle config-write enable to the debug port
- dbg_in  in  8  debug port output (combinational from its config register)
- byte_data  out  8  sampled value
- byte_valid  out  1  byte_data valid
- byte_ready  in  1  downstream accepts byte
- frame_first  out  1  high together with byte_valid on the first byte (code 0) of each frame
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse after the last byte of a frame is accepted

## Operation
- Code sequence, index k = 0..NUM_POT+2:
  - k < NUM_POT: code = k.
  - k = NUM_POT: code 0x1E (layer 1 spikes).
  - k = NUM_POT+1: code 0x1F (layer 2 spikes).
  - k = NUM_POT+2: code 0x20 (layer 3 spikes).
  - Frame length is NUM_POT+3 bytes (27 at default).
- FSM states: IDLE, LOAD, WAIT, SEND, FIN.
  - IDLE: when start=1, set k=0 and go to LOAD.
  - LOAD: cfg_out=code(k), cfg_en=1 for exactly this cycle; load the wait counter with SETTLE; go to WAIT.
  - WAIT: decrement the counter each cycle. On the cycle where the counter reaches 1, capture dbg_in into byte_data, set byte_valid, and go to SEND.
  - SEND: hold byte_data and byte_valid until byte_valid&&byte_ready.
    - If k < NUM_POT+2: increment k, go to LOAD.
    - Otherwise go to FIN.
  - FIN: done=1 for this cycle.
    - If continuous=1: k=0, go to LOAD.
    - Otherwise go to IDLE.
- cfg_out holds its last driven code outside LOAD. cfg_en is 1 only in LOAD.
- frame_first = byte_valid && (k==0).
- start is ignored while busy=1.
- byte_data must not change while byte_valid=1.

## Timing
- Reset (rst_n=0, asynchronous) forces:
  - state IDLE, k=0.
  - cfg_out=0, cfg_en=0, byte_data=0, byte_valid=0, frame_first=0, busy=0, done=0.
- Reset mid-frame abandons the frame immediately. No done pulse is produced. The debug port's config register is not restored.
- start=1 in IDLE at cycle t: LOAD occupies cycle t+1, with cfg_en=1 and busy=1 from t+1.
- The debug port's config register updates at the end of LOAD. dbg_in is sampled at the end of the SETTLE-th WAIT cycle.
- byte_valid rises at LOAD + 1 + SETTLE.
- Per-byte cost with byte_ready held at 1: SETTLE+2 cycles.
- Frame cost: (NUM_POT+3)·(SETTLE+2) cycles plus 1 FIN cycle. This is 82 cycles at the defaults.
- A downstream stall (byte_ready=0) stretches SEND only; no sample is lost or resampled.
- done pulses in the cycle after the final handshake. busy falls the following cycle unless continuous=1.
- In continuous mode busy stays at 1, and the LOAD of code 0 immediately follows FIN.

## Test plan
- Reset: assert rst_n=0 mid-WAIT -> all outputs 0 in the same cycle; after release, IDLE with busy=0 and no done pulse.
- Single frame, defaults, byte_ready=1, with a model debug port where potentials = code+0x40 and layer spikes = 0xA1/0xB2/0xC3 -> exactly 27 bytes, in order 0x40..0x57 then 0xA1, 0xB2, 0xC3.
  - frame_first is set only on byte 0.
  - done arrives 82 cycles after start.
- cfg_en/cfg_out trace -> 27 single-cycle pulses with codes 0x00..0x17, 0x1E, 0x1F, 0x20; cfg_out holds 0x20 after the frame.
- Backpressure: byte_ready=0 for 5 cycles on byte 3 -> byte_valid and byte_data=0x43 stable throughout; change dbg_in during the stall -> no effect on byte_data; frame content unchanged.
- SETTLE=3: sample timing -> byte_valid 4 cycles after each cfg_en; frame length 27·5+1 = 136 cycles.
- continuous=1 for two frames, then cleared; start pulsed while busy -> two done pulses, 54 bytes, then IDLE; the start while busy is ignored.
